// File: rtl/scaled_downsampler_pkg.sv
// Shared definitions for the scaled downsampler: the per-frame mode encoding
// and the width of the tile accumulator.
package scaled_downsampler_pkg;

    typedef enum logic {
        MODE_DECIMATE = 1'b0,
        MODE_AVERAGE  = 1'b1
    } mode_e;

    function automatic int sum_width(input int data_w, input int log2_f);
        return data_w + 2 * log2_f;
    endfunction

endpackage

// File: rtl/downsample_linebuf.sv
// Per-tile-column partial sums carried between the rows of a tile.
// No reset: the first row of every tile ignores whatever is stored here.
module downsample_linebuf #(
    parameter int DEPTH  = 400,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en && (32'(addr) < DEPTH)) begin
            mem_q[addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(addr) < DEPTH) begin
            rd_data = mem_q[addr];
        end
    end

endmodule

// File: rtl/scaled_downsampler.sv
// Raster-stream downsampler: one output per FACTOR x FACTOR tile, either the
// top-left pixel or the floored tile mean, plus one marker sample per blank tile.
module scaled_downsampler
    import scaled_downsampler_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LOG2_F      = 1,
    parameter int ACTIVE_W    = 800,
    parameter int ACTIVE_H    = 600,
    parameter int TOTAL_W     = 840,
    parameter int TOTAL_H     = 640,
    parameter int BLANK_VALUE = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    output logic [DATA_W-1:0] dataout,
    output logic              validout,
    output logic              blankingregion,
    output logic              frame_done
);

    localparam int F         = 1 << LOG2_F;
    localparam int COL_W     = $clog2(TOTAL_W);
    localparam int ROW_W     = $clog2(TOTAL_H);
    localparam int HSUM_W    = DATA_W + LOG2_F;
    localparam int SUM_W     = sum_width(DATA_W, LOG2_F);
    localparam int LB_DEPTH  = ACTIVE_W / F;
    localparam int LB_ADDR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    mode_e             mode_q, mode_d;
    logic [HSUM_W-1:0] hsum_q, hsum_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              validout_q, validout_d;
    logic              blank_out_q, blank_out_d;
    logic              frame_done_q, frame_done_d;

    logic                 blank, advance, col_wrap, row_wrap;
    logic                 tile_row_first, tile_row_last, tile_col_first, tile_col_last;
    mode_e                mode_eff;
    logic [LB_ADDR_W-1:0] lb_addr;
    logic                 lb_wr_en;
    logic [SUM_W-1:0]     lb_rd, lb_prev, tile_sum;
    logic [HSUM_W-1:0]    hsum_prev;
    logic [DATA_W-1:0]    tile_avg;

    downsample_linebuf #(
        .DEPTH (LB_DEPTH),
        .WIDTH (SUM_W),
        .ADDR_W(LB_ADDR_W)
    ) u_linebuf (
        .clock  (clock),
        .wr_en  (lb_wr_en),
        .addr   (lb_addr),
        .wr_data(tile_sum),
        .rd_data(lb_rd)
    );

    always_comb begin
        blank    = (row_q >= ROW_W'(ACTIVE_H)) || (col_q >= COL_W'(ACTIVE_W));
        advance  = valid || blank;
        col_wrap = (col_q == COL_W'(TOTAL_W - 1));
        row_wrap = (row_q == ROW_W'(TOTAL_H - 1));

        tile_row_first = ((row_q & ROW_W'(F - 1)) == '0);
        tile_row_last  = ((row_q & ROW_W'(F - 1)) == ROW_W'(F - 1));
        tile_col_first = ((col_q & COL_W'(F - 1)) == '0);
        tile_col_last  = ((col_q & COL_W'(F - 1)) == COL_W'(F - 1));

        // The frame's first pixel already follows the newly sampled mode.
        mode_eff = ((row_q == '0) && (col_q == '0)) ? mode_e'(mode) : mode_q;
        mode_d   = mode_eff;

        lb_addr   = LB_ADDR_W'(col_q >> LOG2_F);
        hsum_prev = tile_col_first ? '0 : hsum_q;
        lb_prev   = tile_row_first ? '0 : lb_rd;
        tile_sum  = lb_prev + SUM_W'(hsum_prev) + SUM_W'(data);
        tile_avg  = DATA_W'(tile_sum >> (2 * LOG2_F));

        col_d = col_q;
        row_d = row_q;
        if (col_wrap) begin
            col_d = '0;
            row_d = row_wrap ? '0 : row_q + ROW_W'(1);
        end else if (advance) begin
            col_d = col_q + COL_W'(1);
        end
        frame_done_d = col_wrap && row_wrap;

        hsum_d      = hsum_q;
        lb_wr_en    = 1'b0;
        dataout_d   = '0;
        validout_d  = 1'b0;
        blank_out_d = 1'b0;

        if (advance) begin
            if (blank) begin
                if (tile_row_first && tile_col_first) begin
                    validout_d  = 1'b1;
                    dataout_d   = DATA_W'(BLANK_VALUE);
                    blank_out_d = 1'b1;
                end
            end else if (mode_eff == MODE_DECIMATE) begin
                if (tile_row_first && tile_col_first) begin
                    validout_d = 1'b1;
                    dataout_d  = data;
                end
            end else begin
                hsum_d = hsum_prev + HSUM_W'(data);
                if (tile_col_last) begin
                    if (tile_row_last) begin
                        validout_d = 1'b1;
                        dataout_d  = tile_avg;
                    end else begin
                        lb_wr_en = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= MODE_DECIMATE;
            hsum_q       <= '0;
            dataout_q    <= '0;
            validout_q   <= 1'b0;
            blank_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            hsum_q       <= hsum_d;
            dataout_q    <= dataout_d;
            validout_q   <= validout_d;
            blank_out_q  <= blank_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dataout        = dataout_q;
    assign validout       = validout_q;
    assign blankingregion = blank_out_q;
    assign frame_done     = frame_done_q;

endmodule
